alu_arbiter: RTL

Shares one combinational ALU instance between NUM_REQ requesters (e.g. integer pipe, address-gen unit, debug port). Accepts one operation at a time via valid/ready, drives the ALU operand/control ports for one cycle, registers the result and returns it to the granted requester via a resp valid/ready handshake. Round-robin fairness; sits between requesters and the ALU in the core datapath.

---
 rtl/alu_arbiter.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one combinational ALU among NUM_REQ requesters.
// Define ALU_ARB_PERF_EN to add the perf_ops / perf_stall counters.
module alu_arbiter #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned IDW     = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [4*NUM_REQ-1:0]  req_ctrl,
    input  logic [32*NUM_REQ-1:0] req_opr1,
    input  logic [32*NUM_REQ-1:0] req_opr2,
    output logic [NUM_REQ-1:0]    resp_valid,
    input  logic [NUM_REQ-1:0]    resp_ready,
    output logic [31:0]           resp_data,
    output logic                  resp_zero,
    output logic [31:0]           alu_opr1,
    output logic [31:0]           alu_opr2,
    output logic [3:0]            alu_ctrl,
    input  logic [31:0]           alu_out,
    input  logic                  alu_zero,
`ifdef ALU_ARB_PERF_EN
    output logic [31:0]           perf_ops,
    output logic [31:0]           perf_stall,
`endif
    output logic                  busy
);

    localparam int unsigned DW = 32;
    localparam int unsigned CW = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0]   owner_q, owner_d;
    logic [CW-1:0]    ctrl_q, ctrl_d;
    logic [DW-1:0]    opr1_q, opr1_d;
    logic [DW-1:0]    opr2_q, opr2_d;
    logic [DW-1:0]    data_q, data_d;
    logic             zero_q, zero_d;

    logic [NUM_REQ-1:0]   valid_gated_c;
    logic [2*NUM_REQ-1:0] valid_dbl_c;
    logic [NUM_REQ-1:0]   valid_rot_c;
    logic [NUM_REQ-1:0]   grant_oh_c;
    logic [NUM_REQ-1:0]   owner_oh_c;
    logic [IDW-1:0]       grant_idx_c;
    logic                 grant_vld_c;
    logic                 owner_ready_c;
    logic [CW-1:0]        sel_ctrl_c;
    logic [DW-1:0]        sel_opr1_c;
    logic [DW-1:0]        sel_opr2_c;

    // Reduce an index in [0, 2*NUM_REQ) back into [0, NUM_REQ).
    function automatic logic [IDW-1:0] wrap_idx(input int unsigned v);
        int unsigned r;
        r = (v >= NUM_REQ) ? (v - NUM_REQ) : v;
        return IDW'(r);
    endfunction

    // Rotate the requests so bit 0 is the rr_ptr requester, then take the first set bit.
    always_comb begin
        valid_gated_c = req_valid & {NUM_REQ{rst_n}};
        valid_dbl_c   = {valid_gated_c, valid_gated_c};
        valid_rot_c   = NUM_REQ'(valid_dbl_c >> rr_ptr_q);
        grant_vld_c   = 1'b0;
        grant_idx_c   = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (!grant_vld_c && valid_rot_c[k]) begin
                grant_vld_c = 1'b1;
                grant_idx_c = wrap_idx(32'(rr_ptr_q) + k);
            end
        end
    end

    // One-hot decodes and operand select for the granted requester.
    always_comb begin
        grant_oh_c = '0;
        owner_oh_c = '0;
        sel_ctrl_c = '0;
        sel_opr1_c = '0;
        sel_opr2_c = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            grant_oh_c[i] = grant_vld_c && (grant_idx_c == IDW'(i));
            owner_oh_c[i] = (owner_q == IDW'(i));
            if (grant_idx_c == IDW'(i)) begin
                sel_ctrl_c = req_ctrl[CW*i +: CW];
                sel_opr1_c = req_opr1[DW*i +: DW];
                sel_opr2_c = req_opr2[DW*i +: DW];
            end
        end
        owner_ready_c = |(resp_ready & owner_oh_c);
    end

    // Next-state and datapath control.
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        owner_d    = owner_q;
        ctrl_d     = ctrl_q;
        opr1_d     = opr1_q;
        opr2_d     = opr2_q;
        data_d     = data_q;
        zero_d     = zero_q;
        req_ready  = '0;
        resp_valid = '0;
        alu_opr1   = '0;
        alu_opr2   = '0;
        alu_ctrl   = '0;

        unique case (state_q)
            IDLE: begin
                req_ready = grant_oh_c;
                if (grant_vld_c) begin
                    owner_d  = grant_idx_c;
                    ctrl_d   = sel_ctrl_c;
                    opr1_d   = sel_opr1_c;
                    opr2_d   = sel_opr2_c;
                    rr_ptr_d = wrap_idx(32'(grant_idx_c) + 32'd1);
                    state_d  = EXEC;
                end
            end
            EXEC: begin
                alu_opr1 = opr1_q;
                alu_opr2 = opr2_q;
                alu_ctrl = ctrl_q;
                data_d   = alu_out;
                zero_d   = alu_zero;
                state_d  = RESP;
            end
            RESP: begin
                resp_valid = owner_oh_c;
                if (owner_ready_c) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            owner_q  <= '0;
            ctrl_q   <= '0;
            opr1_q   <= '0;
            opr2_q   <= '0;
            data_q   <= '0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
            ctrl_q   <= ctrl_d;
            opr1_q   <= opr1_d;
            opr2_q   <= opr2_d;
            data_q   <= data_d;
            zero_q   <= zero_d;
        end
    end

    assign resp_data = data_q;
    assign resp_zero = zero_q;
    assign busy      = (state_q != IDLE);

`ifdef ALU_ARB_PERF_EN
    logic [DW-1:0] perf_ops_q, perf_ops_d;
    logic [DW-1:0] perf_stall_q, perf_stall_d;

    // Completed handshakes vs. cycles the owner holds off a pending result.
    always_comb begin
        perf_ops_d   = perf_ops_q;
        perf_stall_d = perf_stall_q;
        if (state_q == RESP) begin
            if (owner_ready_c) begin
                perf_ops_d = perf_ops_q + 32'd1;
            end else begin
                perf_stall_d = perf_stall_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_ops_q   <= '0;
            perf_stall_q <= '0;
        end else begin
            perf_ops_q   <= perf_ops_d;
            perf_stall_q <= perf_stall_d;
        end
    end

    assign perf_ops   = perf_ops_q;
    assign perf_stall = perf_stall_q;
`endif

endmodule
